// File: rtl/ps2_command_sender.sv
// ps2_command_sender
//   Host-to-device PS/2 transmitter. It sends one command byte to the keyboard
//   over the open-drain ps2_clk/ps2_dat pair. The sequence is: request-to-send,
//   then start bit, 8 data bits LSB first, odd parity and stop, all clocked by
//   the device. The block then checks the device ACK bit.
//
// Ports
//   clock      system clock
//   resetn     synchronous, active-low reset
//   cmd_data   command byte, captured when a transfer is accepted
//   cmd_valid  request to send cmd_data
//   cmd_ready  high while idle and able to accept (cmd_valid & cmd_ready = accept)
//   ps2_clk    open-drain clock line (driven 0 or released)
//   ps2_dat    open-drain data line (driven 0 or released)
//   busy       high whenever a transmission is in progress
//   done       one-cycle pulse: device acknowledged (ACK bit = 0)
//   error      one-cycle pulse: device NACK (ACK bit = 1) or timeout
module ps2_command_sender #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  inout  wire        ps2_clk,
  inout  wire        ps2_dat,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int INH_W = (INHIBIT_CYCLES < 2) ? 1 : $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t             state_q, state_d;
  logic [INH_W-1:0]   inh_cnt_q, inh_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         byte_q, byte_d;
  logic               parity_q, parity_d;
  logic               nack_q, nack_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  // Two-flop synchronizers plus one history flop on the clock line for edge detect.
  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic dat_meta_q, dat_sync_q;

  logic clk_low;
  logic dat_low;
  logic [2:0] bit_idx;
  logic fall;
  logic timeout;

  assign fall    = clk_prev_q & ~clk_sync_q;
  assign timeout = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Open-drain drivers: only ever pull low or release.
  assign ps2_clk = clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = dat_low ? 1'b0 : 1'bz;

  // State register
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      inh_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      byte_q     <= '0;
      parity_q   <= 1'b0;
      nack_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      inh_cnt_q  <= inh_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_q     <= byte_d;
      parity_q   <= parity_d;
      nack_q     <= nack_d;
      done_q     <= done_d;
      error_q    <= error_d;
      clk_meta_q <= ps2_clk;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_dat;
      dat_sync_q <= dat_meta_q;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    inh_cnt_d = inh_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    bit_cnt_d = bit_cnt_q;
    byte_d    = byte_q;
    parity_d  = parity_q;
    nack_d    = nack_q;
    done_d    = 1'b0;
    error_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          byte_d    = cmd_data;
          parity_d  = ~^cmd_data;
          inh_cnt_d = '0;
          state_d   = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
          state_d = S_RTS;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end

      S_RTS: begin
        bit_cnt_d = '0;
        tmo_cnt_d = '0;
        state_d   = S_SEND;
      end

      S_SEND: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (timeout) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else if (fall) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          // The tenth fall moves on to the stop bit, which is a released line.
          if (bit_cnt_q == 4'd9) begin
            state_d = S_ACK;
          end
        end
      end

      S_ACK: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (timeout) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else if (fall) begin
          nack_d  = dat_sync_q;
          state_d = S_WAIT_IDLE;
        end
      end

      S_WAIT_IDLE: begin
        if (clk_sync_q && dat_sync_q) begin
          done_d  = ~nack_q;
          error_d = nack_q;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    clk_low = 1'b0;
    dat_low = 1'b0;
    bit_idx = 3'(bit_cnt_q - 4'd1);

    case (state_q)
      S_INHIBIT: begin
        clk_low = 1'b1;
      end
      S_RTS: begin
        clk_low = 1'b1;
        dat_low = 1'b1;
      end
      S_SEND: begin
        if (bit_cnt_q == 4'd0) begin
          dat_low = 1'b1;                 // start bit
        end else if (bit_cnt_q <= 4'd8) begin
          dat_low = ~byte_q[bit_idx];
        end else if (bit_cnt_q == 4'd9) begin
          dat_low = ~parity_q;
        end
      end
      default: begin
        clk_low = 1'b0;
        dat_low = 1'b0;
      end
    endcase

    busy  = (state_q != S_IDLE);
    // Held off during the result pulse so a new command starts the cycle after it.
    cmd_ready = (state_q == S_IDLE) && !done_q && !error_q;
    done  = done_q;
    error = error_q;
  end

endmodule

// File: tb/tb_ps2_command_sender.sv
module tb_ps2_command_sender;

  localparam int INH = 300;
  localparam int TMO = 3000;

  // Outcome kinds for a transaction
  localparam int K_ACK     = 0;
  localparam int K_NACK    = 1;
  localparam int K_TIMEOUT = 2;
  localparam int K_RESET   = 3;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       busy;
  logic       done;
  logic       error;
  wire        ps2_clk;
  wire        ps2_dat;

  logic bfm_clk_low = 1'b0;
  logic bfm_dat_low = 1'b0;

  pullup (ps2_clk);
  pullup (ps2_dat);
  assign ps2_clk = bfm_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = bfm_dat_low ? 1'b0 : 1'bz;

  always #5 clock = ~clock;

  ps2_command_sender #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  typedef struct {
    logic [7:0] cmd;
    int         kind;
  } exp_t;

  typedef struct {
    logic [10:0] bits;
    int          n;
  } obs_t;

  exp_t exp_q[$];
  obs_t obs_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference frame as the device should sample it: start, data LSB first,
  // odd parity (set when the byte has an even number of ones), stop.
  function automatic logic [10:0] model_frame(input logic [7:0] c);
    logic [10:0] f;
    int ones;
    int b;
    ones = 0;
    f = '0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b = (int'(c) >> i) % 2;
      ones += b;
      f[i + 1] = (b == 1);
    end
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // ------------------------------------------------------------------
  // Monitor: wire timing plus result scoreboard
  // ------------------------------------------------------------------
  int  cyc = 0;
  int  acc_cyc, rts_cyc, rel_cyc, low_cnt;
  bit  in_tx = 0, rts_seen = 0, rel_seen = 0;
  bit  prev_busy = 0, pulse_prev = 0;

  initial begin
    exp_t e;
    obs_t o;
    logic [10:0] mask;
    logic [10:0] ref_f;
    forever begin
      @(negedge clock);
      cyc++;
      if (pulse_prev) begin
        check("pulse_width", int'(done | error), 0);
        check("ready_after_pulse", int'(cmd_ready), 1);
        pulse_prev = 0;
      end
      if (!prev_busy && busy) begin
        check("clk_low_on_accept", int'(ps2_clk), 0);
        check("ready_low_on_accept", int'(cmd_ready), 0);
        in_tx = 1; acc_cyc = cyc; low_cnt = 0; rts_seen = 0; rel_seen = 0;
      end
      if (in_tx && !rel_seen) begin
        if (ps2_clk == 1'b0) low_cnt++;
        if (!rts_seen && ps2_dat == 1'b0) begin
          rts_seen = 1;
          rts_cyc = cyc;
          check("inhibit_len", rts_cyc - acc_cyc, INH);
        end else if (rts_seen && ps2_clk == 1'b1) begin
          rel_seen = 1;
          rel_cyc = cyc;
          check("clk_low_total", low_cnt, INH + 1);
          check("rts_to_release", rel_cyc - rts_cyc, 1);
          check("dat_low_at_release", int'(ps2_dat), 0);
        end
      end
      if (done || error) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: got done=%0b error=%0b, expected none", done, error);
        end else begin
          e = exp_q.pop_front();
          check("done_flag", int'(done), (e.kind == K_ACK) ? 1 : 0);
          check("error_flag", int'(error), (e.kind == K_ACK) ? 0 : 1);
          check("busy_at_pulse", int'(busy), 0);
          check("ready_low_at_pulse", int'(cmd_ready), 0);
          if (e.kind == K_TIMEOUT) begin
            check("timeout_cycles", cyc - rel_cyc, TMO);
            check("clk_released_timeout", int'(ps2_clk), 1);
            check("dat_released_timeout", int'(ps2_dat), 1);
          end
          if (obs_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_missing: got no sampled frame, expected one for cmd %02h", e.cmd);
          end else begin
            o = obs_q.pop_front();
            check("frame_len", o.n, (e.kind == K_TIMEOUT) ? 4 : 11);
            mask  = 11'((1 << o.n) - 1);
            ref_f = model_frame(e.cmd);
            check("frame_bits", int'(o.bits & mask), int'(ref_f & mask));
          end
          $display("txn cmd=%02h kind=%0d done=%0b error=%0b cycle=%0d", e.cmd, e.kind, done, error, cyc);
        end
        pulse_prev = 1;
        in_tx = 0;
      end
      prev_busy = busy;
    end
  end

  // ------------------------------------------------------------------
  // Stimulus and device BFM
  // ------------------------------------------------------------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_cmd(input logic [7:0] c, input int kind, input int half);
    int t;
    int nfalls;
    obs_t o;
    exp_t e;
    o.bits = '0;
    o.n = 0;

    t = 0;
    @(negedge clock);
    while (!cmd_ready && t < 20000) begin
      @(negedge clock);
      t++;
    end
    if (!cmd_ready) begin
      check("ready_wait", 0, 1);
      return;
    end
    if (kind != K_RESET) begin
      e.cmd = c;
      e.kind = kind;
      exp_q.push_back(e);
    end
    cmd_data  = c;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    cmd_data  = 8'($urandom);     // must not affect the transfer

    t = 0;
    while (!(ps2_clk == 1'b1 && ps2_dat == 1'b0) && t < INH + 100) begin
      @(negedge clock);
      t++;
    end
    if (t >= INH + 100) begin
      check("release_wait", 0, 1);
      return;
    end

    nfalls = (kind == K_TIMEOUT) ? 4 : (kind == K_RESET) ? 5 : 10;
    wait_cycles(half);
    for (int k = 0; k < nfalls; k++) begin
      o.bits[k] = ps2_dat;
      o.n++;
      bfm_clk_low = 1'b1;
      wait_cycles(half);
      bfm_clk_low = 1'b0;
      wait_cycles(half);
    end

    if (kind == K_TIMEOUT) begin
      obs_q.push_back(o);
      return;
    end

    if (kind == K_RESET) begin
      check("dat_driven_before_reset", int'(ps2_dat), 0);
      resetn = 1'b0;
      @(negedge clock);
      check("clk_released_on_reset", int'(ps2_clk), 1);
      check("dat_released_on_reset", int'(ps2_dat), 1);
      check("busy_after_reset", int'(busy), 0);
      check("no_pulse_on_reset", int'(done | error), 0);
      resetn = 1'b1;
      wait_cycles(10);
      return;
    end

    o.bits[10] = ps2_dat;        // stop bit
    o.n++;
    obs_q.push_back(o);

    // ACK clock: device pulls data low (ACK) or leaves it high (NACK).
    if (kind == K_ACK) bfm_dat_low = 1'b1;
    wait_cycles(2);
    bfm_clk_low = 1'b1;
    wait_cycles(half);
    bfm_clk_low = 1'b0;
    wait_cycles(half);
    bfm_dat_low = 1'b0;
    wait_cycles(4);
  endtask

  initial begin
    int t;
    int kind;
    // Reset with the bus floating high
    wait_cycles(5);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_error", int'(error), 0);
    check("rst_clk_released", int'(ps2_clk), 1);
    check("rst_dat_released", int'(ps2_dat), 1);
    resetn = 1'b1;
    wait_cycles(3);
    check("idle_ready", int'(cmd_ready), 1);
    check("idle_busy", int'(busy), 0);

    // cmd_valid while not ready must be ignored: pulse it during inhibit
    send_cmd(8'hED, K_ACK, 10);
    send_cmd(8'hF4, K_ACK, 8);
    send_cmd(8'h00, K_ACK, 12);
    send_cmd(8'hFF, K_NACK, 9);
    send_cmd(8'hA5, K_TIMEOUT, 10);
    send_cmd(8'h00, K_RESET, 10);
    send_cmd(8'h55, K_ACK, 10);

    for (int i = 0; i < 8; i++) begin
      kind = ($urandom_range(0, 3) == 0) ? K_NACK : K_ACK;
      send_cmd(8'($urandom_range(0, 255)), kind, $urandom_range(6, 20));
    end

    t = 0;
    while (exp_q.size() != 0 && t < 10000) begin
      @(negedge clock);
      t++;
    end
    check("pending_results", exp_q.size(), 0);
    wait_cycles(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Stray cmd_valid pulses while busy must not start anything: the scoreboard
  // would flag an extra accept as a wrong inhibit length or extra pulse.
  initial begin
    forever begin
      @(negedge clock);
      if (busy && !cmd_valid && $urandom_range(0, 50) == 0) begin
        cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ps2_command_sender.md
# ps2_command_sender

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard over the same open-drain ps2_clk/ps2_dat pair used by the scan-code receive path. It runs the PS/2 host request-to-send sequence and shifts out start, 8 data bits LSB first, odd parity and stop, all clocked by the device. It then checks the device ACK. A `busy` output tells the receive path to ignore bus traffic while a transmission is in progress.

## Interface
- INHIBIT_CYCLES, 5000: clock cycles ps2_clk is held low before request-to-send (100 us at 50 MHz).
- TIMEOUT_CYCLES, 1000000: maximum cycles from clock release to ACK sample (20 ms at 50 MHz).
- clock  input  1  system clock, 50 MHz.
- resetn  input  1  reset, synchronous, active-low.
- cmd_data  input  8  command byte; sampled on accept.
- cmd_valid  input  1  request to send cmd_data.
- cmd_ready  output  1  high only in IDLE; a transfer is accepted on cmd_valid & cmd_ready.
- ps2_clk  inout  1  open-drain; block drives 1'b0 or 1'bz only.
- ps2_dat  inout  1  open-drain; block drives 1'b0 or 1'bz only.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse: device ACKed (ACK bit = 0).
- error  output  1  one-cycle pulse: ACK bit = 1, or timeout.

## Operation
- Both PS/2 inputs pass through a 2-flop synchronizer. A falling edge of ps2_clk (fall) is synced previous = 1, synced current = 0.
- States:
  - IDLE: lines released. On accept, latch byte; parity = ~^byte. Go to INHIBIT and clear the cycle counter.
  - INHIBIT: drive ps2_clk low. After INHIBIT_CYCLES cycles go to RTS.
  - RTS: drive ps2_clk low and ps2_dat low for exactly 1 cycle. Then go to SEND with bit counter = 0 and timeout counter = 0.
  - SEND: release ps2_clk; ps2_dat stays driven low (start bit). On each fall, the bit counter increments to k:
    - k = 1..8: drive data bit k-1 (1 = release, 0 = drive low).
    - k = 9: drive parity.
    - k = 10: release ps2_dat (stop) and go to ACK.
  - ACK: lines released. On the next fall, sample synced ps2_dat. 0 → WAIT_IDLE with result = ok. 1 → WAIT_IDLE with result = fail.
  - WAIT_IDLE: wait until synced ps2_clk = 1 and synced ps2_dat = 1 on the same cycle. Then pulse done (ok) or error (fail) and go to IDLE.
- Timeout: the counter runs in SEND and ACK. When it reaches TIMEOUT_CYCLES, release both lines, pulse error and go directly to IDLE.
- cmd_valid while not ready is ignored. cmd_data changes after accept have no effect.
- Falls seen in IDLE, INHIBIT or RTS are ignored. Device traffic in IDLE is the receiver's concern.

## Timing
- Reset values: cmd_ready = 1, busy = 0, done = 0, error = 0; both lines released; state = IDLE.
- Reset mid-operation: lines are released on the clock edge where resetn is sampled low.
- Accept at edge N: busy = 1, cmd_ready = 0 and ps2_clk driven low from edge N.
- ps2_clk low for INHIBIT_CYCLES + 1 cycles total, including the RTS cycle.
- ps2_dat is driven low one cycle before ps2_clk is released.
- Data update latency: 3 clock cycles after the physical falling edge of ps2_clk (2 sync + 1 register). This is well inside the ≥5 us clock-low half period.
- done and error are mutually exclusive, registered, and high for exactly 1 cycle.
- cmd_ready rises on the cycle after the done/error pulse; back-to-back commands are allowed from then.

## Test plan
- Reset with lines floating high → cmd_ready = 1, busy = 0, ps2_clk = ps2_dat = z.
- Device BFM, cmd 0xED:
  - ps2_clk held low 5000 cycles, then ps2_dat low.
  - Bits sampled on BFM rising edges: 0, then 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - BFM ACK 0 → single done pulse; busy drops.
- cmd 0xF4 → parity 0 on the wire. cmd 0x00 → parity 1. Both ACKed → done pulse.
- cmd 0xFF with BFM NACK (ps2_dat left high at edge 11) → single error pulse, no done.
- BFM stops clocking after 4 falls → error pulse exactly TIMEOUT_CYCLES after clock release; lines released; cmd_ready = 1.
- resetn low during SEND at bit 5 → lines released next edge; no done/error. A new 0x55 command then completes with done.
